bcd_mod_counter: RTL
====================

BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 SHALL have parameter MODULUS, default 60, count modulus; legal range 2..100.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port en  input  1  count enable, level-sensitive, sampled on rising clk.
REQ-005 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 SHALL have port load  input  1  synchronous load request.
REQ-007 SHALL have port load_val  input  8  load value as BCD: [7:4] tens digit, [3:0] ones digit.
REQ-008 SHALL have port count  output  8  current count as BCD: [7:4] tens digit, [3:0] ones digit.
REQ-009 SHALL have port tc  output  1  terminal-count (wrap) pulse.
REQ-010 SHALL have port load_err  output  1  rejected-load pulse.

Function
REQ-011 SHALL drive count, tc and load_err directly from registers; no combinational path from any input to any output.
REQ-012 SHALL give load priority over en on the same edge; up SHALL be ignored during a load.
REQ-013 SHALL, on load=1 with both digits <=9 and value < MODULUS, set count=load_val after that edge, with tc=0 and load_err=0.
REQ-014 SHALL, on load=1 with either digit >9 or value >= MODULUS, leave count unchanged, set load_err=1 for exactly one cycle and set tc=0.
REQ-015 SHALL, on en=1 and load=0, update count by exactly one decimal step per edge: up=1 adds 1, up=0 subtracts 1.
REQ-016 SHALL carry on increment: ones 9 -> 0 with tens+1; SHALL borrow on decrement: ones 0 -> 9 with tens-1.
REQ-017 SHALL wrap on increment from MODULUS-1 to 00 and on decrement from 00 to MODULUS-1.
REQ-018 SHALL assert tc=1 for exactly the one cycle in which count first shows the wrapped value (same edge as the wrap), else tc=0.
REQ-019 SHALL hold count and drive tc=0, load_err=0 on any edge with en=0 and load=0.
REQ-020 SHALL apply a change of up on the next enabled edge, with no extra or skipped step.
REQ-021 SHALL never present a digit >9 or a value >= MODULUS on count.
REQ-022 SHALL, for MODULUS=100, wrap 99 -> 00 up and 00 -> 99 down; for MODULUS<=10, keep tens=0.

Reset
REQ-023 SHALL, when reset_n=0, immediately force count=8'h00, tc=0 and load_err=0, independent of clk.
REQ-024 SHALL hold those values for as long as reset_n=0, ignoring en, load and up.
REQ-025 SHALL, after reset_n rises, resume normal operation at the first rising clk edge, starting from count 00.
REQ-026 SHALL abort any count step or load in progress when reset_n falls mid-cycle; no partial update SHALL remain.

Verification
REQ-027 Bench SHALL check, with MODULUS=60: reset, then en=1 up=1 for 60 edges -> count 00..59 then 00; tc=1 only on the 59->00 edge.
REQ-028 Bench SHALL check: load 8'h00, then en=1 up=0 for one edge -> count=8'h59 and tc=1 for one cycle.
REQ-029 Bench SHALL check: load=1 load_val=8'h3A -> count unchanged, load_err=1 for one cycle; load_val=8'h60 -> same response.
REQ-030 Bench SHALL check: load=1 en=1 load_val=8'h42 on the same edge -> count=8'h42, no step, tc=0.
REQ-031 Bench SHALL check: at count=8'h19 with en=1 up=1 -> 8'h20; then up=0 -> 8'h19 on the next edge.
REQ-032 Bench SHALL check: reset_n pulsed low between clk edges at count=8'h37 -> count=8'h00 before the next edge, tc=0, load_err=0.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter with programmable modulus, synchronous validated load,
// a one-cycle wrap pulse (tc) and a one-cycle rejected-load pulse (load_err).
module bcd_mod_counter #(
  parameter int unsigned MODULUS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       tc,
  output logic       load_err
);

  localparam int unsigned MaxVal  = MODULUS - 1;
  localparam logic [3:0]  MaxTens = 4'(MaxVal / 10);
  localparam logic [3:0]  MaxOnes = 4'(MaxVal % 10);
  localparam logic [7:0]  ModBin  = 8'(MODULUS);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       tc_q, tc_d;
  logic       load_err_q, load_err_d;

  logic [3:0] ld_tens, ld_ones;
  logic [7:0] ld_bin;
  logic       ld_ok;
  logic       at_max, at_zero;

  always_comb begin
    ld_tens = load_val[7:4];
    ld_ones = load_val[3:0];
    // tens*10 + ones, built from shifts so the compare stays 8 bits wide
    ld_bin  = {1'b0, ld_tens, 3'b000} + {3'b000, ld_tens, 1'b0} + {4'b0000, ld_ones};
    ld_ok   = (ld_tens <= 4'd9) && (ld_ones <= 4'd9) && (ld_bin < ModBin);
    at_max  = (tens_q == MaxTens) && (ones_q == MaxOnes);
    at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  end

  always_comb begin
    tens_d     = tens_q;
    ones_d     = ones_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (ld_ok) begin
        tens_d = ld_tens;
        ones_d = ld_ones;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          tens_d = 4'd0;
          ones_d = 4'd0;
          tc_d   = 1'b1;
        end else if (ones_q == 4'd9) begin
          tens_d = tens_q + 4'd1;
          ones_d = 4'd0;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          tens_d = MaxTens;
          ones_d = MaxOnes;
          tc_d   = 1'b1;
        end else if (ones_q == 4'd0) begin
          tens_d = tens_q - 4'd1;
          ones_d = 4'd9;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = {tens_q, ones_q};
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule
